// File: rtl/decode_prefix_sequencer_if.sv
// Queue-side and decoder-side signals of the prefix sequencer.
// master = queue/decoder environment, slave = sequencer.
interface decode_prefix_sequencer_if;
    logic            i_flush;
    logic [3:0][7:0] i_queue_byte;
    logic [2:0]      i_queue_count;
    logic [2:0]      o_queue_consume;
    logic            o_valid;
    logic            i_ready;
    logic            o_lock;
    logic            o_repeat_not_equal;
    logic            o_repeat_equal;
    logic            o_segment_override;
    logic [2:0]      o_segment_override_index;
    logic            o_operand_size;
    logic            o_address_size;
    logic [3:0]      o_prefix_count;
    logic            o_error;

    modport master (
        output i_flush, i_queue_byte, i_queue_count, i_ready,
        input  o_queue_consume, o_valid, o_lock, o_repeat_not_equal, o_repeat_equal,
               o_segment_override, o_segment_override_index, o_operand_size,
               o_address_size, o_prefix_count, o_error
    );

    modport slave (
        input  i_flush, i_queue_byte, i_queue_count, i_ready,
        output o_queue_consume, o_valid, o_lock, o_repeat_not_equal, o_repeat_equal,
               o_segment_override, o_segment_override_index, o_operand_size,
               o_address_size, o_prefix_count, o_error
    );
endinterface

// File: rtl/decode_prefix_sequencer.sv
// x86 prefix sequencer: scans up to four queue-head bytes per cycle, accumulates
// prefix state across cycles and hands one registered summary per instruction.

// Per-byte classifier; grp is one-hot {G4,G3,G2,G1}, all zero for an opcode byte.
module decode_prefix_lane (
    input  logic [7:0] qbyte,
    output logic [3:0] grp,
    output logic       lock,
    output logic       rep_ne,
    output logic       rep_eq,
    output logic [2:0] seg_idx
);
    always_comb begin
        grp     = '0;
        lock    = 1'b0;
        rep_ne  = 1'b0;
        rep_eq  = 1'b0;
        seg_idx = '0;
        case (qbyte)
            8'hF0: begin grp[0] = 1'b1; lock   = 1'b1; end
            8'hF2: begin grp[0] = 1'b1; rep_ne = 1'b1; end
            8'hF3: begin grp[0] = 1'b1; rep_eq = 1'b1; end
            8'h26: begin grp[1] = 1'b1; seg_idx = 3'd0; end
            8'h2E: begin grp[1] = 1'b1; seg_idx = 3'd1; end
            8'h36: begin grp[1] = 1'b1; seg_idx = 3'd2; end
            8'h3E: begin grp[1] = 1'b1; seg_idx = 3'd3; end
            8'h64: begin grp[1] = 1'b1; seg_idx = 3'd4; end
            8'h65: begin grp[1] = 1'b1; seg_idx = 3'd5; end
            8'h66: grp[2] = 1'b1;
            8'h67: grp[3] = 1'b1;
            default: ;
        endcase
    end
endmodule

module decode_prefix_sequencer #(
    parameter int MAX_PREFIX_BYTES = 14
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    decode_prefix_sequencer_if.slave     bus
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {S_SCAN, S_HOLD, S_ERROR} state_t;
    typedef enum logic [1:0] {STOP_NONE, STOP_OPC, STOP_DUP, STOP_LEN} stop_t;

    state_t state;

    logic [3:0] grp_q;
    logic       lock_q, rne_q, req_q;
    logic [2:0] seg_idx_q;
    logic [3:0] cnt_q;
    logic       valid_q, err_q;

    logic [NUM_LANES-1:0][3:0] lane_grp;
    logic [NUM_LANES-1:0][2:0] lane_seg;
    logic [NUM_LANES-1:0]      lane_lock, lane_rne, lane_req;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        decode_prefix_lane u_lane (
            .qbyte   (bus.i_queue_byte[g]),
            .grp     (lane_grp[g]),
            .lock    (lane_lock[g]),
            .rep_ne  (lane_rne[g]),
            .rep_eq  (lane_req[g]),
            .seg_idx (lane_seg[g])
        );
    end

    logic [2:0] n_acc;
    stop_t      reason;
    logic       stopped;
    logic [3:0] win_grp;
    logic       w_lock, w_rne, w_req;
    logic [2:0] w_seg;

    // Accept the longest in-order run of prefixes; the first refusal decides why we stopped.
    always_comb begin
        n_acc   = '0;
        reason  = STOP_NONE;
        stopped = 1'b0;
        win_grp = '0;
        w_lock  = 1'b0;
        w_rne   = 1'b0;
        w_req   = 1'b0;
        w_seg   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!stopped && (3'(k) < bus.i_queue_count)) begin
                if (lane_grp[k] == 4'd0) begin
                    stopped = 1'b1;
                    reason  = STOP_OPC;
                end else if (|((grp_q | win_grp) & lane_grp[k])) begin
                    stopped = 1'b1;
                    reason  = STOP_DUP;
                end else if (({1'b0, cnt_q} + 5'(k) + 5'd1) > 5'(MAX_PREFIX_BYTES)) begin
                    stopped = 1'b1;
                    reason  = STOP_LEN;
                end else begin
                    n_acc   = n_acc + 3'd1;
                    win_grp = win_grp | lane_grp[k];
                    w_lock  = w_lock | lane_lock[k];
                    w_rne   = w_rne | lane_rne[k];
                    w_req   = w_req | lane_req[k];
                    w_seg   = w_seg | lane_seg[k];
                end
            end
        end
    end

    assign bus.o_queue_consume = (state == S_SCAN && !i_reset && !bus.i_flush) ? n_acc : 3'd0;

    always_ff @(posedge i_clock) begin
        if (i_reset || bus.i_flush) begin
            state     <= S_SCAN;
            grp_q     <= '0;
            lock_q    <= 1'b0;
            rne_q     <= 1'b0;
            req_q     <= 1'b0;
            seg_idx_q <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_SCAN: begin
                    grp_q     <= grp_q | win_grp;
                    lock_q    <= lock_q | w_lock;
                    rne_q     <= rne_q | w_rne;
                    req_q     <= req_q | w_req;
                    seg_idx_q <= seg_idx_q | w_seg;
                    cnt_q     <= cnt_q + {1'b0, n_acc};
                    if (reason == STOP_OPC) begin
                        state   <= S_HOLD;
                        valid_q <= 1'b1;
                    end else if (reason == STOP_DUP || reason == STOP_LEN) begin
                        state   <= S_ERROR;
                        valid_q <= 1'b1;
                        err_q   <= 1'b1;
                    end
                end
                S_HOLD, S_ERROR: begin
                    if (bus.i_ready) begin
                        state     <= S_SCAN;
                        grp_q     <= '0;
                        lock_q    <= 1'b0;
                        rne_q     <= 1'b0;
                        req_q     <= 1'b0;
                        seg_idx_q <= '0;
                        cnt_q     <= '0;
                        valid_q   <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                default: state <= S_SCAN;
            endcase
        end
    end

    assign bus.o_valid                  = valid_q;
    assign bus.o_error                  = err_q;
    assign bus.o_lock                   = lock_q;
    assign bus.o_repeat_not_equal       = rne_q;
    assign bus.o_repeat_equal           = req_q;
    assign bus.o_segment_override       = grp_q[1];
    assign bus.o_segment_override_index = seg_idx_q;
    assign bus.o_operand_size           = grp_q[2];
    assign bus.o_address_size           = grp_q[3];
    assign bus.o_prefix_count           = cnt_q;
endmodule

// File: tb/tb_decode_prefix_sequencer.sv
// Directed cases plus a randomized byte-stream run against a whole-instruction prefix model.
module tb_decode_prefix_sequencer;
    localparam int MAX0 = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_prefix_sequencer_if ifc0 ();
    decode_prefix_sequencer_if ifc2 ();

    decode_prefix_sequencer #(.MAX_PREFIX_BYTES(MAX0)) u_dut (
        .i_clock (clk), .i_reset (rst), .bus (ifc0)
    );
    decode_prefix_sequencer #(.MAX_PREFIX_BYTES(2)) u_dut2 (
        .i_clock (clk), .i_reset (rst), .bus (ifc2)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [14:0] sum0, sum2;
    assign sum0 = {ifc0.o_valid, ifc0.o_error, ifc0.o_lock, ifc0.o_repeat_not_equal,
                   ifc0.o_repeat_equal, ifc0.o_segment_override, ifc0.o_segment_override_index,
                   ifc0.o_operand_size, ifc0.o_address_size, ifc0.o_prefix_count};
    assign sum2 = {ifc2.o_valid, ifc2.o_error, ifc2.o_lock, ifc2.o_repeat_not_equal,
                   ifc2.o_repeat_equal, ifc2.o_segment_override, ifc2.o_segment_override_index,
                   ifc2.o_operand_size, ifc2.o_address_size, ifc2.o_prefix_count};

    function automatic logic [14:0] mk(bit v, bit e, bit lk, bit rn, bit re, bit sg,
                                       logic [2:0] si, bit os, bit as, logic [3:0] pc);
        return {v, e, lk, rn, re, sg, si, os, as, pc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic win0(input logic [7:0] b0, b1, b2, b3, input int c);
        ifc0.i_queue_byte[0] = b0; ifc0.i_queue_byte[1] = b1;
        ifc0.i_queue_byte[2] = b2; ifc0.i_queue_byte[3] = b3;
        ifc0.i_queue_count = 3'(c);
    endtask

    task automatic win2(input logic [7:0] b0, b1, b2, b3, input int c);
        ifc2.i_queue_byte[0] = b0; ifc2.i_queue_byte[1] = b1;
        ifc2.i_queue_byte[2] = b2; ifc2.i_queue_byte[3] = b3;
        ifc2.i_queue_count = 3'(c);
    endtask

    // Reference model: prefix classification and whole-run parse of the byte stream.
    logic [7:0] strm[$];

    function automatic int grp_of(logic [7:0] b);
        case (b)
            8'hF0, 8'hF2, 8'hF3:                             return 0;
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65:        return 1;
            8'h66:                                           return 2;
            8'h67:                                           return 3;
            default:                                         return -1;
        endcase
    endfunction

    function automatic logic [2:0] seg_of(logic [7:0] b);
        case (b)
            8'h2E: return 3'd1;
            8'h36: return 3'd2;
            8'h3E: return 3'd3;
            8'h64: return 3'd4;
            8'h65: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    // kind: 0 opcode stop, 1 duplicate group, 2 length limit
    function automatic void parse(output int p, output int kind, output logic [14:0] sm);
        bit [3:0] seen = '0;
        bit lk = 0, rn = 0, re = 0;
        logic [2:0] si = '0;
        p = 0;
        kind = 0;
        for (int i = 0; i < strm.size(); i++) begin
            int g = grp_of(strm[i]);
            if (g < 0) begin kind = 0; break; end
            if (seen[g]) begin kind = 1; break; end
            if (p + 1 > MAX0) begin kind = 2; break; end
            seen[g] = 1'b1;
            p++;
            if (strm[i] == 8'hF0) lk = 1;
            if (strm[i] == 8'hF2) rn = 1;
            if (strm[i] == 8'hF3) re = 1;
            if (g == 1) si = seg_of(strm[i]);
        end
        sm = mk(1, kind != 0, lk, rn, re, seen[1], si, seen[2], seen[3], 4'(p));
    endfunction

    task automatic drop_through_opcode();
        while (strm.size() > 0) begin
            logic [7:0] b = strm.pop_front();
            if (grp_of(b) < 0) break;
        end
    endtask

    logic [7:0] pfx_tab [11] = '{8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36,
                                 8'h3E, 8'h64, 8'h65, 8'h66, 8'h67};

    initial begin
        int p, kind, s, cyc;
        bit vphase;
        logic [14:0] esum;

        rst = 1'b1;
        ifc0.i_flush = 0; ifc0.i_ready = 0; win0(8'hF0, 8'h66, 8'h67, 8'h26, 4);
        ifc2.i_flush = 0; ifc2.i_ready = 0; win2(0, 0, 0, 0, 0);
        tick();
        #3;
        chk("rst_consume", ifc0.o_queue_consume, 0);
        chk("rst_outputs", sum0, 0);
        rst = 1'b0;
        win0(0, 0, 0, 0, 0);
        tick();

        // 2E 66 8B
        win0(8'h2E, 8'h66, 8'h8B, 8'h00, 3);
        #3 chk("t1_consume", ifc0.o_queue_consume, 2);
        tick();
        win0(8'h8B, 0, 0, 0, 1);
        #3 chk("t1_summary", sum0, mk(1, 0, 0, 0, 0, 1, 3'd1, 1, 0, 4'd2));
        chk("t1_hold_consume", ifc0.o_queue_consume, 0);
        ifc0.i_ready = 1;
        tick();
        ifc0.i_ready = 0; win0(0, 0, 0, 0, 0);
        #3 chk("t1_idle", sum0, 0);
        tick();

        // bare opcode, held with ready low
        win0(8'h90, 0, 0, 0, 1);
        #3 chk("t2_consume", ifc0.o_queue_consume, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            #3 chk("t2_stable", sum0, mk(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 4'd0));
            if (i == 5) ifc0.i_ready = 1;
            tick();
        end
        ifc0.i_ready = 0; win0(0, 0, 0, 0, 0);
        #3 chk("t2_idle", ifc0.o_valid, 0);
        tick();

        // fragmented run F3 26 67 66 then A5
        foreach (pfx_tab[i]) if (0) ;
        begin
            logic [7:0] frag [4] = '{8'hF3, 8'h26, 8'h67, 8'h66};
            for (int i = 0; i < 4; i++) begin
                win0(frag[i], 8'h00, 8'h00, 8'h00, 1);
                #3 chk("t3_consume", ifc0.o_queue_consume, 1);
                tick();
            end
        end
        win0(8'hA5, 0, 0, 0, 1);
        #3 chk("t3_opc_consume", ifc0.o_queue_consume, 0);
        tick();
        #3 chk("t3_summary", sum0, mk(1, 0, 0, 0, 1, 1, 3'd0, 1, 1, 4'd4));
        ifc0.i_ready = 1;
        tick();
        ifc0.i_ready = 0; win0(0, 0, 0, 0, 0);
        tick();

        // duplicate 66 then flush
        win0(8'h66, 8'h2E, 8'h66, 8'h90, 4);
        #3 chk("t4_consume", ifc0.o_queue_consume, 2);
        tick();
        win0(8'h66, 8'h90, 0, 0, 2);
        #3 chk("t4_error", sum0, mk(1, 1, 0, 0, 0, 1, 3'd1, 1, 0, 4'd2));
        ifc0.i_flush = 1;
        #1 chk("t4_flush_consume", ifc0.o_queue_consume, 0);
        tick();
        ifc0.i_flush = 0; win0(0, 0, 0, 0, 0);
        #3 chk("t4_after_flush", sum0, 0);
        tick();

        // reset during HOLD with ready high
        win0(8'h90, 0, 0, 0, 1);
        tick();
        rst = 1; ifc0.i_ready = 1;
        #3 chk("t6_rst_consume", ifc0.o_queue_consume, 0);
        tick();
        rst = 0; ifc0.i_ready = 0; win0(0, 0, 0, 0, 0);
        #3 chk("t6_rst_outputs", sum0, 0);
        tick();

        // flush with a prefix window
        ifc0.i_flush = 1; win0(8'hF0, 8'h66, 8'h67, 8'h26, 4);
        #3 chk("t6_flush_consume", ifc0.o_queue_consume, 0);
        tick();
        ifc0.i_flush = 0; win0(0, 0, 0, 0, 0);
        #3 chk("t6_flush_nomerge", sum0, 0);
        tick();

        // MAX_PREFIX_BYTES = 2 instance
        win2(8'hF0, 8'h66, 8'h67, 8'h8B, 4);
        #3 chk("t5_consume", ifc2.o_queue_consume, 2);
        tick();
        win2(8'h67, 8'h8B, 0, 0, 2);
        #3 chk("t5_len_error", sum2, mk(1, 1, 1, 0, 0, 0, 3'd0, 1, 0, 4'd2));
        ifc2.i_ready = 1;
        tick();
        ifc2.i_ready = 0; win2(0, 0, 0, 0, 0);
        #3 chk("t5_idle", sum2, 0);
        tick();
        win2(8'h26, 8'hF2, 8'h90, 8'h00, 3);
        #3 chk("t5_full_consume", ifc2.o_queue_consume, 2);
        tick();
        win2(8'h90, 0, 0, 0, 1);
        #3 chk("t5_full_hold", sum2, mk(1, 0, 0, 1, 0, 1, 3'd0, 0, 0, 4'd2));
        ifc2.i_ready = 1;
        tick();
        ifc2.i_ready = 0;
        win2(8'h66, 0, 0, 0, 1);
        #3 chk("t5_frag_a", ifc2.o_queue_consume, 1);
        tick();
        win2(8'h67, 0, 0, 0, 1);
        #3 chk("t5_frag_b", ifc2.o_queue_consume, 1);
        tick();
        win2(8'hF0, 0, 0, 0, 1);
        #3 chk("t5_frag_limit", ifc2.o_queue_consume, 0);
        tick();
        #3 chk("t5_frag_error", sum2, mk(1, 1, 0, 0, 0, 0, 3'd0, 1, 1, 4'd2));
        ifc2.i_flush = 1;
        tick();
        ifc2.i_flush = 0; win2(0, 0, 0, 0, 0);
        tick();

        // randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            int plen = $urandom_range(0, 5);
            logic [7:0] op;
            for (int j = 0; j < plen; j++) strm.push_back(pfx_tab[$urandom_range(0, 10)]);
            do op = 8'($urandom); while (grp_of(op) >= 0);
            strm.push_back(op);
        end
        parse(p, kind, esum);
        s = 0;
        vphase = 0;
        cyc = 0;
        while (strm.size() > 0 && cyc < 20000) begin
            int c, ec;
            bit fl, rd, stop_seen;
            cyc++;
            c = $urandom_range(0, strm.size() < 4 ? strm.size() : 4);
            for (int k = 0; k < 4; k++)
                ifc0.i_queue_byte[k] = (k < c) ? strm[k] : 8'($urandom);
            ifc0.i_queue_count = 3'(c);
            fl = ($urandom_range(0, 39) == 0);
            rd = ($urandom_range(0, 2) != 0);
            if (vphase && kind != 0) begin
                fl = $urandom_range(0, 1) == 1;
                rd = 1;
            end
            ifc0.i_flush = fl;
            ifc0.i_ready = rd;
            ec = 0;
            stop_seen = 0;
            #3;
            if (vphase) begin
                chk("rnd_summary", sum0, esum);
                chk("rnd_hold_consume", ifc0.o_queue_consume, 0);
            end else begin
                ec = fl ? 0 : ((c < p - s) ? c : p - s);
                stop_seen = !fl && (c > p - s);
                chk("rnd_consume", ifc0.o_queue_consume, ec);
                chk("rnd_idle", ifc0.o_valid, 0);
            end
            tick();
            if (vphase) begin
                if (fl || rd) begin
                    vphase = 0;
                    if (kind != 0) drop_through_opcode();
                    else if (!fl) void'(strm.pop_front());
                    if (strm.size() > 0) parse(p, kind, esum);
                    s = 0;
                end
            end else if (fl) begin
                parse(p, kind, esum);
                s = 0;
            end else begin
                for (int k = 0; k < ec; k++) void'(strm.pop_front());
                s += ec;
                if (stop_seen) vphase = 1;
            end
        end
        ifc0.i_flush = 0; ifc0.i_ready = 0; win0(0, 0, 0, 0, 0);
        chk("rnd_stream_drained", strm.size(), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
